// File: rtl/deadlock_kernel_monitor_param.sv
// deadlock_kernel_monitor_param
//
// Watches a kernel's AXI-stream stall flags and its sub-instance idle/block
// flags. A deadlock is declared only after the deadlock condition has held for
// a programmable number of consecutive cycles. On declaration it latches
// diagnostics that a bench or debug register bank can read back.
//
// Ports:
//   kernel_monitor_clock  in   monitor clock
//   kernel_monitor_reset  in   asynchronous active-low reset
//   axis_block_sigs       in   [N_AXIS]     1 = stream port stalled
//   inst_idle_sigs        in   [N_INST]     1 = instance idle
//   inst_block_sigs       in   [N_INST]     1 = instance internally blocked
//   timeout_cycles        in   [TIMEOUT_W]  persistence threshold (0 acts as 1)
//   clear                 in   synchronous clear of detection state/diagnostics
//   block                 out  kernel deadlock declared
//   block_pulse           out  one-cycle strobe on each entry into BLOCKED
//   block_axis_snap       out  [N_AXIS]     axis_block_sigs captured at detection
//   block_idx             out  [IDX_W]      lowest set bit of block_axis_snap
//   block_idx_valid       out  block_axis_snap is nonzero
//   stall_count           out  [TIMEOUT_W]  cycles spent in BLOCKED, saturating
//   block_events          out  [EVT_W]      number of BLOCKED entries, saturating
module deadlock_kernel_monitor_param #(
  parameter int N_AXIS    = 4,
  parameter int N_INST    = 2,
  parameter int TIMEOUT_W = 16,
  parameter int EVT_W     = 8,
  parameter int STICKY    = 1,
  parameter int IDX_W     = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
  input  logic                 kernel_monitor_clock,
  input  logic                 kernel_monitor_reset,
  input  logic [N_AXIS-1:0]    axis_block_sigs,
  input  logic [N_INST-1:0]    inst_idle_sigs,
  input  logic [N_INST-1:0]    inst_block_sigs,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 clear,
  output logic                 block,
  output logic                 block_pulse,
  output logic [N_AXIS-1:0]    block_axis_snap,
  output logic [IDX_W-1:0]     block_idx,
  output logic                 block_idx_valid,
  output logic [TIMEOUT_W-1:0] stall_count,
  output logic [EVT_W-1:0]     block_events
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUSPECT = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] T_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W:0]   T_ONEX = (TIMEOUT_W+1)'(1);
  localparam logic [EVT_W-1:0]     E_ONE  = EVT_W'(1);

  function automatic logic [TIMEOUT_W-1:0] sat_inc_t(input logic [TIMEOUT_W-1:0] v);
    return (&v) ? v : v + T_ONE;
  endfunction

  function automatic logic [EVT_W-1:0] sat_inc_e(input logic [EVT_W-1:0] v);
    return (&v) ? v : v + E_ONE;
  endfunction

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   block_q, block_d;
  logic                   pulse_q, pulse_d;
  logic [N_AXIS-1:0]      snap_q, snap_d;
  logic [TIMEOUT_W-1:0]   stall_q, stall_d;
  logic [EVT_W-1:0]       events_q, events_d;

  logic                   candidate;
  logic [TIMEOUT_W-1:0]   t_eff;
  logic [TIMEOUT_W:0]     cnt_inc;
  logic                   enter;

  // Every instance parked (idle or blocked) and at least one blocking flag set.
  assign candidate = (&(inst_idle_sigs | inst_block_sigs)) &
                     ((|axis_block_sigs) | (|inst_block_sigs));
  assign t_eff     = (timeout_cycles == '0) ? T_ONE : timeout_cycles;
  // One bit wider so the compare cannot wrap when cnt is at all-ones.
  assign cnt_inc   = {1'b0, cnt_q} + T_ONEX;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (candidate) begin
          if (t_eff == T_ONE) begin
            state_d = S_BLOCKED;
            enter   = 1'b1;
          end else begin
            state_d = S_SUSPECT;
            cnt_d   = T_ONE;
          end
        end
      end
      S_SUSPECT: begin
        if (!candidate) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= {1'b0, t_eff}) begin
          state_d = S_BLOCKED;
          enter   = 1'b1;
        end else begin
          cnt_d = cnt_inc[TIMEOUT_W-1:0];
        end
      end
      S_BLOCKED: begin
        if ((STICKY == 0) && !candidate) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Clear beats any transition, including the entry edge.
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      enter   = 1'b0;
    end
  end

  always_comb begin
    block_d  = (state_d == S_BLOCKED);
    pulse_d  = enter;
    snap_d   = enter ? axis_block_sigs : snap_q;
    events_d = enter ? sat_inc_e(events_q) : events_q;
    // Restart on entry; count each cycle spent in BLOCKED, including the
    // release cycle. The value is kept after a non-sticky release.
    if (enter) begin
      stall_d = '0;
    end else if (state_q == S_BLOCKED) begin
      stall_d = sat_inc_t(stall_q);
    end else begin
      stall_d = stall_q;
    end
    if (clear) begin
      block_d  = 1'b0;
      pulse_d  = 1'b0;
      snap_d   = '0;
      events_d = '0;
      stall_d  = '0;
    end
  end

  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
    if (!kernel_monitor_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      block_q  <= 1'b0;
      pulse_q  <= 1'b0;
      snap_q   <= '0;
      stall_q  <= '0;
      events_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
      pulse_q  <= pulse_d;
      snap_q   <= snap_d;
      stall_q  <= stall_d;
      events_q <= events_d;
    end
  end

  // Lowest-index priority: scan from the top so the lowest set bit wins.
  always_comb begin
    block_idx = '0;
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (snap_q[i]) begin
        block_idx = IDX_W'(i);
      end
    end
  end

  assign block_idx_valid = |snap_q;
  assign block           = block_q;
  assign block_pulse     = pulse_q;
  assign block_axis_snap = snap_q;
  assign stall_count     = stall_q;
  assign block_events    = events_q;

endmodule

// File: tb/tb_deadlock_kernel_monitor_param.sv
// Bench for deadlock_kernel_monitor_param. Two instances share the stimulus:
// A is sticky with a 4-bit timeout/stall width, B is non-sticky with 16 bits.
// Expected values come from a run-length model of the detection rules.
module tb_deadlock_kernel_monitor_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  axis = '0;
  logic [1:0]  idle = '0;
  logic [1:0]  iblk = '0;
  logic [15:0] tmo = 16'd4;

  logic        a_block, a_pulse, a_valid;
  logic [3:0]  a_snap;
  logic [1:0]  a_idx;
  logic [3:0]  a_stall;
  logic [7:0]  a_evt;
  logic        b_block, b_pulse, b_valid;
  logic [3:0]  b_snap;
  logic [1:0]  b_idx;
  logic [15:0] b_stall;
  logic [7:0]  b_evt;

  deadlock_kernel_monitor_param #(
    .N_AXIS(4), .N_INST(2), .TIMEOUT_W(4), .EVT_W(8), .STICKY(1)
  ) dut_a (
    .kernel_monitor_clock(clk),
    .kernel_monitor_reset(rst_n),
    .axis_block_sigs(axis),
    .inst_idle_sigs(idle),
    .inst_block_sigs(iblk),
    .timeout_cycles(tmo[3:0]),
    .clear(clear),
    .block(a_block),
    .block_pulse(a_pulse),
    .block_axis_snap(a_snap),
    .block_idx(a_idx),
    .block_idx_valid(a_valid),
    .stall_count(a_stall),
    .block_events(a_evt)
  );

  deadlock_kernel_monitor_param #(
    .N_AXIS(4), .N_INST(2), .TIMEOUT_W(16), .EVT_W(8), .STICKY(0)
  ) dut_b (
    .kernel_monitor_clock(clk),
    .kernel_monitor_reset(rst_n),
    .axis_block_sigs(axis),
    .inst_idle_sigs(idle),
    .inst_block_sigs(iblk),
    .timeout_cycles(tmo),
    .clear(clear),
    .block(b_block),
    .block_pulse(b_pulse),
    .block_axis_snap(b_snap),
    .block_idx(b_idx),
    .block_idx_valid(b_valid),
    .stall_count(b_stall),
    .block_events(b_evt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model, index 0 = A, 1 = B.
  int         m_run   [2];
  bit         m_blk   [2];
  bit         m_pulse [2];
  logic [3:0] m_snap  [2];
  int         m_stall [2];
  int         m_evt   [2];

  function automatic int stall_max(input int d);
    return (d == 0) ? 15 : 65535;
  endfunction

  function automatic bit m_cand();
    bit parked = 1'b1;
    bit any    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!(idle[i] || iblk[i])) parked = 1'b0;
      if (iblk[i]) any = 1'b1;
    end
    for (int i = 0; i < 4; i++) if (axis[i]) any = 1'b1;
    return parked && any;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_blk[d] = 0; m_pulse[d] = 0;
      m_snap[d] = '0; m_stall[d] = 0; m_evt[d] = 0;
    end
  endtask

  // One rising edge: blocked once the run of consecutive candidate edges
  // reaches the threshold in force at that edge.
  task automatic model_edge();
    bit c = m_cand();
    int t = (tmo == 0) ? 1 : int'(tmo);
    for (int d = 0; d < 2; d++) begin
      m_pulse[d] = 0;
      if (clear) begin
        m_run[d] = 0; m_blk[d] = 0; m_snap[d] = '0; m_stall[d] = 0; m_evt[d] = 0;
      end else if (m_blk[d]) begin
        if (m_stall[d] < stall_max(d)) m_stall[d]++;
        if (d == 1 && !c) begin
          m_blk[d] = 0;
          m_run[d] = 0;
        end
      end else begin
        m_run[d] = c ? m_run[d] + 1 : 0;
        if (m_run[d] >= t) begin
          m_blk[d] = 1; m_pulse[d] = 1; m_snap[d] = axis; m_stall[d] = 0;
          m_run[d] = 0;
          if (m_evt[d] < 255) m_evt[d]++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string p, input int d, input logic blk, input logic pls,
                         input logic [3:0] snap, input logic [1:0] idx, input logic vld,
                         input logic [15:0] stall, input logic [7:0] evt);
    int eidx = 0;
    for (int i = 3; i >= 0; i--) if (m_snap[d][i]) eidx = i;
    chk({p, ".block"},  32'(blk),   32'(m_blk[d]));
    chk({p, ".pulse"},  32'(pls),   32'(m_pulse[d]));
    chk({p, ".snap"},   32'(snap),  32'(m_snap[d]));
    chk({p, ".idx"},    32'(idx),   32'(eidx));
    chk({p, ".valid"},  32'(vld),   32'(m_snap[d] != 0));
    chk({p, ".stall"},  32'(stall), 32'(m_stall[d]));
    chk({p, ".events"}, 32'(evt),   32'(m_evt[d]));
  endtask

  task automatic check_all();
    chk_dut("A", 0, a_block, a_pulse, a_snap, a_idx, a_valid, 16'(a_stall), a_evt);
    chk_dut("B", 1, b_block, b_pulse, b_snap, b_idx, b_valid, b_stall, b_evt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_cand_axis();
    idle = 2'b10; iblk = 2'b01; axis = 4'b0100;
  endtask

  task automatic set_quiet();
    idle = 2'b10; iblk = 2'b00; axis = 4'b0000;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    chk("reset.a_block", 32'(a_block), 32'd0);
    #1;
    rst_n = 1'b1;

    // 1: T=4, detection after the 4th candidate edge.
    tmo = 16'd4;
    set_cand_axis();
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) chk("t1.block_e3", 32'(a_block), 32'd0);
    end
    chk("t1.block_e4", 32'(a_block), 32'd1);
    chk("t1.pulse_e4", 32'(b_pulse), 32'd1);
    chk("t1.idx", 32'(a_idx), 32'd2);
    chk("t1.events", 32'(b_evt), 32'd1);
    do_clear();

    // 2: a one-cycle drop restarts the count.
    for (int i = 0; i < 3; i++) tick();
    set_quiet();
    tick();
    set_cand_axis();
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) chk("t2.block_e3", 32'(a_block), 32'd0);
      if (i == 3) chk("t2.events_e3", 32'(a_evt), 32'd0);
    end
    chk("t2.block_e4", 32'(a_block), 32'd1);
    do_clear();

    // 3: timeout 0 behaves as 1; instance-only block gives invalid idx.
    tmo = 16'd0;
    idle = 2'b10; iblk = 2'b01; axis = 4'b0000;
    tick();
    chk("t3.block", 32'(a_block), 32'd1);
    chk("t3.valid", 32'(a_valid), 32'd0);

    // 4: sticky hold with candidate gone; A stall saturates at 15.
    set_quiet();
    for (int i = 0; i < 20; i++) tick();
    chk("t4.a_block", 32'(a_block), 32'd1);
    chk("t4.a_stall_sat", 32'(a_stall), 32'd15);
    chk("t4.b_block", 32'(b_block), 32'd0);
    do_clear();
    chk("t4.a_clear", 32'(a_block), 32'd0);

    // 5: non-sticky re-entry.
    tmo = 16'd2;
    set_cand_axis();
    for (int i = 0; i < 5; i++) tick();
    set_quiet();
    tick();
    chk("t5.b_released", 32'(b_block), 32'd0);
    chk("t5.b_stall_kept", 32'(b_stall), 32'd4);
    tick();
    set_cand_axis();
    tick();
    tick();
    chk("t5.b_events", 32'(b_evt), 32'd2);
    chk("t5.b_stall_restart", 32'(b_stall), 32'd0);
    do_clear();

    // 6: async reset in SUSPECT and in BLOCKED.
    tmo = 16'd4;
    set_cand_axis();
    tick();
    tick();
    async_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) chk("t6.block_e3", 32'(b_block), 32'd0);
    end
    chk("t6.block_e4", 32'(b_block), 32'd1);
    async_reset();
    chk("t6.rst_block", 32'(a_block), 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      idle  = 2'($urandom);
      iblk  = 2'($urandom);
      axis  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      tmo   = 16'($urandom_range(0, 5));
      clear = ($urandom_range(0, 30) == 0);
      tick();
      if ($urandom_range(0, 60) == 0) async_reset();
    end
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
